dw3_31_calc: RTL and testbench
==============================

DW3_31_CALC -- requirements
Module: dw3_31_calc

Interface
REQ-001 SHALL have parameter LR_SHIFT, default 2: learning rate eta = 2^-LR_SHIFT, legal range 0..8.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one delta-weight computation; sampled only in IDLE.
REQ-005 SHALL have port a3_1  input  16  output-neuron activation, signed Q6.10 (00_0000.0000_0000_00).
REQ-006 SHALL have port t1  input  16  training target, signed Q6.10.
REQ-007 SHALL have port a2_1  input  16  hidden-neuron activation feeding w3_31, signed Q6.10.
REQ-008 SHALL have port dw3_31  output  16  delta weight, signed Q6.10; feeds the w3_31 weight register.
REQ-009 SHALL have port dw_valid  output  1  one-cycle strobe, dw3_31 new; drives the weight block's select_update.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL compute dw3_31 = -eta * delta3_1 * a2_1, where delta3_1 = (a3_1 - t1) * a3_1 * (1.0 - a3_1) and 1.0 = 16'sd1024.
REQ-012 SHALL use FSM states IDLE, ERR, DERIV, DELTA, GRAD, OUT, one state per clock.
REQ-013 IDLE with start=1 SHALL latch a3_1, t1 and a2_1 into internal registers and go to ERR; IDLE with start=0 SHALL stay in IDLE.
REQ-014 ERR SHALL register e = sat16(a3 - t), computed at 17 bits; then go to DERIV.
REQ-015 DERIV SHALL register p = qmul(a3, sat16(1024 - a3)); then go to DELTA.
REQ-016 DELTA SHALL register d = qmul(e, p); then go to GRAD.
REQ-017 GRAD SHALL register g = qmul(d, a2); then go to OUT.
REQ-018 OUT SHALL load dw3_31 = sat16(-(g >>> LR_SHIFT)), pulse dw_valid for exactly one cycle, and return to IDLE.
REQ-019 qmul(x,y) SHALL form the full 32-bit signed product, arithmetic-shift right by 10 (floor, no rounding), then apply sat16.
REQ-020 sat16 SHALL clamp to [-32768, +32767]; negating -32768 SHALL yield +32767.
REQ-021 Latency SHALL be 5 clocks: start sampled at edge N, dw3_31 updated and dw_valid high after edge N+5.
REQ-022 Minimum spacing between accepted starts SHALL be 6 clocks; start may be accepted in the IDLE cycle directly after OUT.
REQ-023 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 Input changes after the accepting edge SHALL NOT affect the result in flight.
REQ-025 dw3_31 SHALL hold its last value between computations; dw_valid SHALL never be high for two consecutive cycles, because downstream accumulates once per high cycle.
REQ-026 A held start SHALL restart a computation each time the FSM reaches IDLE, one result per 6 clocks.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, dw3_31=0, dw_valid=0, busy=0, and clear all internal and latched registers.
REQ-028 Reset asserted mid-computation SHALL abort it with no dw_valid pulse; the first start after deassertion SHALL behave as after power-up.

Verification
REQ-029 a3_1=768 (0.75), t1=1024, a2_1=512, LR_SHIFT=2, one-cycle start -> internal e=-256, p=192, d=-48, g=-24; dw3_31=6 with dw_valid high for exactly one cycle, 5 clocks after start.
REQ-030 a3_1=t1=614, a2_1=1024 -> dw3_31=0, dw_valid pulses once.
REQ-031 Saturation case: a3_1=16'h7FFF, t1=16'h8000, a2_1=1024, LR_SHIFT=2 -> e=32767, p=-32768, d=-32768, g=-32768; dw3_31=8192.
REQ-032 Apply start; pulse start again 2 clocks later; change all inputs 1 clock after acceptance -> exactly one dw_valid, value matches the originally latched inputs.
REQ-033 Assert reset asynchronously (between edges) while in DELTA -> outputs zero at once, no dw_valid; a subsequent REQ-029 stimulus reproduces dw3_31=6.
REQ-034 start held high for 20 clocks with REQ-029 inputs -> dw_valid pulses at 6-clock spacing, each with dw3_31=6.

Source files
------------

// File: rtl/dw3_31_calc_if.sv
// ---------------------------------------------------------------------------
// dw3_31_calc_if
// Groups the request/result signals of the delta-weight calculator.
//   start    : request one computation (sampled only while the unit is idle)
//   a3_1     : output-neuron activation, signed Q6.10
//   t1       : training target, signed Q6.10
//   a2_1     : hidden-neuron activation feeding w3_31, signed Q6.10
//   dw3_31   : delta weight result, signed Q6.10
//   dw_valid : one-cycle strobe, dw3_31 is new
//   busy     : computation in progress
// master = requester (drives operands), slave = calculator.
// ---------------------------------------------------------------------------
interface dw3_31_calc_if;
  logic               start;
  logic signed [15:0] a3_1;
  logic signed [15:0] t1;
  logic signed [15:0] a2_1;
  logic signed [15:0] dw3_31;
  logic               dw_valid;
  logic               busy;

  modport master (
    output start, a3_1, t1, a2_1,
    input  dw3_31, dw_valid, busy
  );

  modport slave (
    input  start, a3_1, t1, a2_1,
    output dw3_31, dw_valid, busy
  );
endinterface

// File: rtl/dw3_31_calc.sv
// ---------------------------------------------------------------------------
// dw3_31_calc
// Computes the delta weight for w3_31:
//   dw3_31 = -eta * (a3_1 - t1) * a3_1 * (1.0 - a3_1) * a2_1,  eta = 2^-LR_SHIFT
// as a six-state sequence (IDLE, ERR, DERIV, DELTA, GRAD, OUT), one step per
// clock, all arithmetic in saturating signed Q6.10.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : slave side of dw3_31_calc_if (start/operands in, result/strobe out)
// ---------------------------------------------------------------------------
module dw3_31_calc #(
  parameter int LR_SHIFT = 2  // legal 0..8
) (
  input  logic          clk,
  input  logic          reset,
  dw3_31_calc_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ERR, DERIV, DELTA, GRAD, OUT} state_t;

  state_t state_q, state_d;

  logic signed [15:0] a3_q, t_q, a2_q;
  logic signed [15:0] e_q, p_q, d_q, g_q;
  logic signed [15:0] dw_q;
  logic               dw_valid_q;

  logic               latch_en;

  // -------------------------------------------------------------------------
  // Arithmetic helpers
  // -------------------------------------------------------------------------
  function automatic logic signed [31:0] ext32(input logic signed [15:0] x);
    return {{16{x[15]}}, x};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7FFF;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

  // Full product fits in 32 bits; >>> floors toward -inf, no rounding.
  function automatic logic signed [15:0] qmul(input logic signed [15:0] x,
                                              input logic signed [15:0] y);
    logic signed [31:0] prod;
    prod = ext32(x) * ext32(y);
    return sat16(prod >>> 10);
  endfunction

  // -------------------------------------------------------------------------
  // Per-step combinational values, each consuming the previous step's register
  // -------------------------------------------------------------------------
  logic signed [15:0] e_calc, p_calc, d_calc, g_calc, dw_calc;
  logic signed [31:0] g_scaled;

  always_comb begin
    e_calc   = sat16(ext32(a3_q) - ext32(t_q));
    p_calc   = qmul(a3_q, sat16(32'sd1024 - ext32(a3_q)));
    d_calc   = qmul(e_q, p_q);
    g_calc   = qmul(d_q, a2_q);
    g_scaled = ext32(g_q) >>> LR_SHIFT;
    // Negation done at 32 bits so -(-32768) saturates to +32767.
    dw_calc  = sat16(-g_scaled);
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch_en = 1'b1;
          state_d  = ERR;
        end
      end
      ERR:     state_d = DERIV;
      DERIV:   state_d = DELTA;
      DELTA:   state_d = GRAD;
      GRAD:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_q       <= '0;
      t_q        <= '0;
      a2_q       <= '0;
      e_q        <= '0;
      p_q        <= '0;
      d_q        <= '0;
      g_q        <= '0;
      dw_q       <= '0;
      dw_valid_q <= 1'b0;
    end else begin
      // Strobe follows OUT by exactly one cycle; OUT never repeats back-to-back.
      dw_valid_q <= (state_q == OUT);
      if (latch_en) begin
        a3_q <= bus.a3_1;
        t_q  <= bus.t1;
        a2_q <= bus.a2_1;
      end
      if (state_q == ERR)   e_q  <= e_calc;
      if (state_q == DERIV) p_q  <= p_calc;
      if (state_q == DELTA) d_q  <= d_calc;
      if (state_q == GRAD)  g_q  <= g_calc;
      if (state_q == OUT)   dw_q <= dw_calc;
    end
  end

  assign bus.dw3_31   = dw_q;
  assign bus.dw_valid = dw_valid_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dw3_31_calc.sv
module tb_dw3_31_calc;
  localparam int LR = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dw3_31_calc_if bus_if();

  dw3_31_calc #(.LR_SHIFT(LR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic longint sat(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic longint fdiv(input longint x, input longint m);
    if (x >= 0) return x / m;
    return -((-x + m - 1) / m);
  endfunction

  function automatic int model_dw(input int a3, input int t, input int a2);
    longint e, p, d, g;
    e = sat(longint'(a3) - t);
    p = sat(fdiv(longint'(a3) * sat(1024 - longint'(a3)), 1024));
    d = sat(fdiv(e * p, 1024));
    g = sat(fdiv(d * a2, 1024));
    return int'(sat(-fdiv(g, longint'(1) << LR)));
  endfunction

  // Cycle-level expectations: a request is accepted when start is seen at an
  // edge no sooner than 6 edges after the previous acceptance; its result
  // appears 5 edges later and the unit is busy in between.
  typedef struct { int edge_no; int value; } pend_t;
  pend_t pend_q[$];
  int  edge_idx  = 0;
  int  next_free = 0;
  int  exp_dw    = 0;
  bit  exp_valid = 0;
  bit  exp_busy  = 0;
  bit  cmp_en    = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q.delete();
      edge_idx  = 0;
      next_free = 0;
      exp_dw    = 0;
      exp_valid = 0;
      exp_busy  = 0;
    end else begin
      int k;
      k = edge_idx;
      edge_idx++;
      if (bus_if.start && k >= next_free) begin
        pend_t p;
        p.edge_no = k + 5;
        p.value   = model_dw(int'(bus_if.a3_1), int'(bus_if.t1), int'(bus_if.a2_1));
        pend_q.push_back(p);
        next_free = k + 6;
      end
      exp_valid = 0;
      if (pend_q.size() > 0 && pend_q[0].edge_no == k) begin
        exp_valid = 1;
        exp_dw    = pend_q[0].value;
        void'(pend_q.pop_front());
      end
      exp_busy = (k < next_free - 1);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_dw_valid", int'(bus_if.dw_valid), int'(exp_valid));
      chk("cyc_dw3_31",   int'(bus_if.dw3_31),   exp_dw);
      chk("cyc_busy",     int'(bus_if.busy),     int'(exp_busy));
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic set_in(input int a3, input int t, input int a2);
    bus_if.a3_1 = 16'(a3);
    bus_if.t1   = 16'(t);
    bus_if.a2_1 = 16'(a2);
  endtask

  // Single-cycle start at the next edge, then wait for the strobe (bounded).
  task automatic run_one(input string name, input int a3, input int t, input int a2,
                         input int exp_val);
    int lat;
    lat = -1;
    set_in(a3, t, a2);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus_if.dw_valid) begin
        lat = i;
        break;
      end
    end
    chk({name, "_latency"}, lat, 5);
    chk({name, "_value"}, int'(bus_if.dw3_31), exp_val);
    @(negedge clk);
    chk({name, "_single_pulse"}, int'(bus_if.dw_valid), 0);
  endtask

  initial begin
    int pulses, last_pulse, a3, t, a2;
    bus_if.start = 1'b0;
    set_in(0, 0, 0);

    // Model pinned to hand-computed values.
    chk("model_basic", model_dw(768, 1024, 512), 6);
    chk("model_equal", model_dw(614, 614, 1024), 0);
    chk("model_sat",   model_dw(32767, -32768, 1024), 8192);

    repeat (2) @(negedge clk);
    chk("reset_dw3_31",   int'(bus_if.dw3_31),   0);
    chk("reset_dw_valid", int'(bus_if.dw_valid), 0);
    chk("reset_busy",     int'(bus_if.busy),     0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    run_one("basic", 768, 1024, 512, 6);
    run_one("equal", 614, 614, 1024, 0);
    run_one("sat", 32767, -32768, 1024, 8192);

    // Retrigger while busy and change inputs after acceptance.
    set_in(768, 1024, 512);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    set_in(-5000, 3000, 20000);
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.dw_valid) begin
        pulses++;
        chk("ignore_value", int'(bus_if.dw3_31), 6);
      end
    end
    chk("ignore_pulses", pulses, 1);

    // Asynchronous reset while in DELTA (two edges after ERR).
    set_in(768, 1024, 512);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    set_in(100, 200, 300);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_dw3_31",   int'(bus_if.dw3_31),   0);
    chk("areset_dw_valid", int'(bus_if.dw_valid), 0);
    chk("areset_busy",     int'(bus_if.busy),     0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.dw_valid) pulses++;
    end
    chk("areset_no_pulse", pulses, 0);
    run_one("after_reset", 768, 1024, 512, 6);

    // Held start: one result every 6 clocks.
    set_in(768, 1024, 512);
    bus_if.start = 1'b1;
    pulses = 0;
    last_pulse = -100;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 19) bus_if.start = 1'b0;
      if (bus_if.dw_valid) begin
        if (pulses > 0) chk("held_spacing", i - last_pulse, 6);
        chk("held_value", int'(bus_if.dw3_31), 6);
        pulses++;
        last_pulse = i;
      end
    end
    chk("held_pulses", pulses, 4);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: a3 = int'($urandom_range(0, 1024));
        1: a3 = ($urandom_range(0, 1)) ? 32767 : -32768;
        default: a3 = int'($urandom_range(0, 65535)) - 32768;
      endcase
      t  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1)) ? 32767 : -32768)
                                       : int'($urandom_range(0, 65535)) - 32768;
      a2 = int'($urandom_range(0, 65535)) - 32768;
      set_in(a3, t, a2);
      bus_if.start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    bus_if.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
